// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional event counters are built in when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_inst,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_inst,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    output logic [XLEN-1:0] alu_inst,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_rd,
    output logic            rsp0_valid,
    output logic [XLEN-1:0] rsp0_rd,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    output logic [XLEN-1:0] rsp1_rd,
    input  logic            rsp1_ready
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_conflict
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } alu_op_t;

    alu_op_t op0;
    alu_op_t op1;
    alu_op_t op_sel;

    logic free0;
    logic free1;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic last_grant;

    assign op0 = '{inst: req0_inst, rs1: req0_rs1, rs2: req0_rs2};
    assign op1 = '{inst: req1_inst, rs1: req1_rs1, rs2: req1_rs2};

    // A slot is reusable when empty or drained by the consumer this cycle.
    assign free0 = !rsp0_valid || rsp0_ready;
    assign free1 = !rsp1_valid || rsp1_ready;
    assign elig0 = rst && req0_valid && free0;
    assign elig1 = rst && req1_valid && free1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        op_sel = '0;
        unique case (1'b1)
            grant0:  op_sel = op0;
            grant1:  op_sel = op1;
            default: op_sel = '0;
        endcase
    end

    assign alu_inst = op_sel.inst;
    assign alu_rs1  = op_sel.rs1;
    assign alu_rs2  = op_sel.rs2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rd    <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rd    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (grant0) begin
                rsp0_rd    <= alu_rd;
                rsp0_valid <= 1'b1;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (grant1) begin
                rsp1_rd    <= alu_rd;
                rsp1_valid <= 1'b1;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic conflict;

    // Counts lost contention, including a requester held off by a full slot.
    assign conflict = req0_valid && req1_valid && (grant0 ^ grant1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant0) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (grant1) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (conflict) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter with a behavioural ALU and per-requester
// result queues filled on grant and drained when responses appear.
module tb_alu_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_inst, req0_rs1, req0_rs2;
    logic [XLEN-1:0] req1_inst, req1_rs1, req1_rs2;
    logic [XLEN-1:0] alu_inst, alu_rs1, alu_rs2, alu_rd;
    logic            rsp0_valid, rsp1_valid;
    logic [XLEN-1:0] rsp0_rd, rsp1_rd;
    logic            rsp0_ready, rsp1_ready;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]     perf_grant0, perf_grant1, perf_conflict;
`endif

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] q0[$];
    logic [XLEN-1:0] q1[$];
    logic            g0, g1;
    logic [XLEN-1:0] seen_inst;

    localparam logic [31:0] ADD = 32'h007302B3;
    localparam logic [31:0] SUB = 32'h407302B3;
    localparam logic [31:0] XOR = 32'h007342B3;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_inst(req0_inst), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_inst(req1_inst), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .alu_inst(alu_inst), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_rd(alu_rd),
        .rsp0_valid(rsp0_valid), .rsp0_rd(rsp0_rd), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rd(rsp1_rd), .rsp1_ready(rsp1_ready)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict)
`endif
    );

    function automatic logic [31:0] alu_model(
        input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
        if (inst[6:0] != 7'h33) return 32'h0;
        case (inst[14:12])
            3'b000:  return inst[30] ? a - b : a + b;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_rd = alu_model(alu_inst, alu_rs1, alu_rs2);

    function automatic logic [XLEN-1:0] pop(input int i);
        if (i == 0) return (q0.size() > 0) ? q0.pop_front() : 'x;
        return (q1.size() > 0) ? q1.pop_front() : 'x;
    endfunction

    // Samples grants mid-cycle, queues expected results, then steps one edge.
    task automatic tick();
        @(negedge clk);
        g0 = req0_ready;
        g1 = req1_ready;
        seen_inst = alu_inst;
        if (g0) q0.push_back(alu_model(req0_inst, req0_rs1, req0_rs2));
        if (g1) q1.push_back(alu_model(req1_inst, req1_rs1, req1_rs2));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] exp;
        rst = 1'b0;
        req0_valid = 1'b1; req0_inst = ADD; req0_rs1 = 32'd3; req0_rs2 = 32'd4;
        req1_valid = 1'b1; req1_inst = SUB; req1_rs1 = 32'd9; req1_rs2 = 32'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got=%b%b want=00", rsp0_valid, rsp1_valid);
        end
        checks++;
        if (alu_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_alu_inst got=%h want=0", alu_inst);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checks++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL first_contention got=%b%b want=10", g0, g1);
        end
        exp = pop(0);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rd !== exp) begin
            errors++;
            $display("FAIL first_rsp got=%b/%h want=1/%h", rsp0_valid, rsp0_rd, exp);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain got=%b want=0", rsp0_valid);
        end
    endtask

    task automatic test_single_op();
        logic [XLEN-1:0] unused;
        req0_valid = 1'b1; req0_inst = ADD; req0_rs1 = 32'd5; req0_rs2 = 32'd7;
        tick();
        req0_valid = 1'b0;
        checks++;
        if (g0 !== 1'b1 || seen_inst !== ADD) begin
            errors++;
            $display("FAIL single_grant got=%b/%h want=1/%h", g0, seen_inst, ADD);
        end
        unused = pop(0);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rd !== 32'd12) begin
            errors++;
            $display("FAIL single_rsp got=%b/%0d want=1/12", rsp0_valid, rsp0_rd);
        end
        tick();
    endtask

    task automatic test_contention();
        logic            exp1;
        logic [XLEN-1:0] exp;
`ifdef ALU_ARB_PERF_EN
        logic [31:0] pg0, pg1, pc;
        pg0 = perf_grant0; pg1 = perf_grant1; pc = perf_conflict;
`endif
        req0_valid = 1'b1; req0_inst = ADD;
        req1_valid = 1'b1; req1_inst = SUB;
        for (int c = 0; c < 8; c++) begin
            req0_rs1 = $urandom; req0_rs2 = $urandom;
            req1_rs1 = $urandom; req1_rs2 = $urandom;
            tick();
            exp1 = (c % 2 == 0);
            checks++;
            if (g1 !== exp1 || g0 !== !exp1) begin
                errors++;
                $display("FAIL contention_%0d got=%b%b want=%b%b", c, g0, g1, !exp1, exp1);
            end
            exp = exp1 ? pop(1) : pop(0);
            checks++;
            if ((exp1 ? rsp1_rd : rsp0_rd) !== exp) begin
                errors++;
                $display("FAIL contention_rd_%0d got=%h want=%h", c,
                         exp1 ? rsp1_rd : rsp0_rd, exp);
            end
        end
`ifdef ALU_ARB_PERF_EN
        checks++;
        if (perf_grant0 - pg0 !== 32'd4 || perf_grant1 - pg1 !== 32'd4 ||
            perf_conflict - pc !== 32'd8) begin
            errors++;
            $display("FAIL perf got=%0d/%0d/%0d want=4/4/8", perf_grant0 - pg0,
                     perf_grant1 - pg1, perf_conflict - pc);
        end
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] hold, exp;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_inst = ADD;
        req0_rs1 = 32'h100; req0_rs2 = 32'h23;
        tick();
        checks++;
        if (g0 !== 1'b1 || rsp0_rd !== 32'h123) begin
            errors++;
            $display("FAIL bp_first got=%b/%h want=1/123", g0, rsp0_rd);
        end
        hold = rsp0_rd;
        req0_rs1 = 32'h40; req0_rs2 = 32'h2;
        req1_valid = 1'b1; req1_inst = XOR;
        for (int c = 0; c < 4; c++) begin
            req1_rs1 = $urandom; req1_rs2 = $urandom;
            tick();
            checks++;
            if (g0 !== 1'b0 || g1 !== 1'b1) begin
                errors++;
                $display("FAIL bp_grant_%0d got=%b%b want=01", c, g0, g1);
            end
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_rd !== hold) begin
                errors++;
                $display("FAIL bp_hold_%0d got=%b/%h want=1/%h", c, rsp0_valid, rsp0_rd, hold);
            end
            exp = pop(1);
            checks++;
            if (rsp1_rd !== exp) begin
                errors++;
                $display("FAIL bp_rsp1_%0d got=%h want=%h", c, rsp1_rd, exp);
            end
        end
        rsp0_ready = 1'b1;
        tick();
        checks++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got=%b%b want=10", g0, g1);
        end
        exp = pop(0);
        exp = pop(0);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rd !== exp || exp !== 32'h42) begin
            errors++;
            $display("FAIL bp_new_rsp got=%b/%h want=1/42", rsp0_valid, rsp0_rd);
        end
        checks++;
        if (rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_rsp1_drain got=%b want=0", rsp1_valid);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] unused;
        req0_valid = 1'b1; req0_inst = XOR;
        req0_rs1 = 32'hF0; req0_rs2 = 32'h0F;
        tick();
        unused = pop(0);
        req0_rs1 = 32'hFF; req0_rs2 = 32'hFF;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rd !== 32'hFF) begin
            errors++;
            $display("FAIL b2b_first got=%b/%h want=1/ff", rsp0_valid, rsp0_rd);
        end
        tick();
        unused = pop(0);
        req0_valid = 1'b0;
        checks++;
        if (g0 !== 1'b1 || rsp0_valid !== 1'b1 || rsp0_rd !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got=%b/%b/%h want=1/1/0", g0, rsp0_valid, rsp0_rd);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got=%b want=0", rsp0_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_inst = ADD;
        req1_rs1 = 32'd20; req1_rs2 = 32'd22;
        tick();
        req1_valid = 1'b0;
        checks++;
        if (g1 !== 1'b1 || rsp1_valid !== 1'b1 || rsp1_rd !== 32'd42) begin
            errors++;
            $display("FAIL mid_grant got=%b/%b/%0d want=1/1/42", g1, rsp1_valid, rsp1_rd);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rsp1_valid !== 1'b0 || rsp1_rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_async got=%b/%h want=0/0", rsp1_valid, rsp1_rd);
        end
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale got=%b%b want=00", rsp0_valid, rsp1_valid);
        end
        rsp1_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
